// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared opcode, PC increment and branch tracker record
package pc_redirect_unit_pkg;
    localparam logic [5:0] OPC_BEQ = 6'd4;
    localparam int         PC_W    = 32;
    localparam int         PC_INC  = 4;
    typedef struct packed {
        logic            valid;
        logic            pred;
        logic [PC_W-1:0] alt_pc;
    } trk_t;
endpackage

// File: rtl/pred_track_slot.sv
// pred_track_slot: one in-flight branch tracker register
//   clk, rst_n : clock, async active-low reset (clears the whole record)
//   load       : capture d
//   clear      : drop the tracked branch (valid <= 0), wins over load
//   d, q       : tracker record in/out
import pc_redirect_unit_pkg::*;
module pred_track_slot (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  trk_t d,
    output trk_t q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (clear) q.valid <= 1'b0;
        else if (load) q <= d;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: next-PC selection, beq prediction tracking and mispredict redirect
//   iPC, iInstruction, iPredTaken : IF-stage PC, instruction, predictor taken bit
//   iStall                        : hold IF/ID, bubble into EX
//   iZeroE                        : EX compare-equal outcome of the tracked beq
//   oNextPC, oFlush               : fetch PC and wrong-path kill
//   oUpdValid/Taken/Miss          : predictor update feedback
//   oBranchCnt, oMissCnt          : saturating resolved/mispredict counters
import pc_redirect_unit_pkg::*;
module pc_redirect_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] iPC,
    input  logic [31:0]       iInstruction,
    input  logic              iPredTaken,
    input  logic              iStall,
    input  logic              iZeroE,
    output logic [ADDR_W-1:0] oNextPC,
    output logic              oFlush,
    output logic              oUpdValid,
    output logic              oUpdTaken,
    output logic              oUpdMiss,
    output logic [CNT_W-1:0]  oBranchCnt,
    output logic [CNT_W-1:0]  oMissCnt
);
    logic              beq_if, pred_if, miss, unused_instr;
    logic [ADDR_W-1:0] seq, tgt, imm_ext, chosen, alt_if;
    trk_t              d_in, d_q, e_q;

    assign unused_instr = ^iInstruction[25:16];
    assign beq_if  = iInstruction[31:26] == OPC_BEQ;
    assign imm_ext = {{(ADDR_W-16){iInstruction[15]}}, iInstruction[15:0]};
    assign seq     = iPC + ADDR_W'(PC_INC);
    assign tgt     = seq + (imm_ext << 2);
    assign pred_if = beq_if & iPredTaken;
    assign chosen  = pred_if ? tgt : seq;
    assign alt_if  = pred_if ? seq : tgt;
    assign d_in    = '{valid: beq_if, pred: pred_if, alt_pc: PC_W'(alt_if)};

    assign miss      = e_q.valid & (iZeroE != e_q.pred);
    assign oUpdValid = e_q.valid;
    assign oUpdTaken = e_q.valid & iZeroE;
    assign oUpdMiss  = miss;
    assign oFlush    = miss;
    assign oNextPC   = miss ? ADDR_W'(e_q.alt_pc) : chosen;

    // A flush also kills the IF instruction: D is cleared rather than loaded from IF.
    pred_track_slot u_d (
        .clk(clk), .rst_n(rst_n), .load(!iStall), .clear(oFlush), .d(d_in), .q(d_q)
    );
    // A stall turns EX into a bubble, so E empties while D holds.
    pred_track_slot u_e (
        .clk(clk), .rst_n(rst_n), .load(1'b1), .clear(oFlush | iStall), .d(d_q), .q(e_q)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            oBranchCnt <= '0;
            oMissCnt   <= '0;
        end else begin
            if (oUpdValid && !(&oBranchCnt)) oBranchCnt <= oBranchCnt + CNT_W'(1);
            if (oUpdMiss && !(&oMissCnt)) oMissCnt <= oMissCnt + CNT_W'(1);
        end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;
    localparam int AW = 32;
    localparam int CW = 8;
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic [AW-1:0] pc;
    logic [31:0]   ins;
    logic          pt, st, z;
    logic [AW-1:0] next_pc;
    logic          flush, upd_v, upd_t, upd_m;
    logic [CW-1:0] bcnt, mcnt;

    typedef struct {
        logic          pred;
        logic [AW-1:0] alt;
    } exp_t;
    exp_t sb[$];
    int   n_tests = 0, n_fail = 0;
    int   ebc = 0, emc = 0;
    int   max_cnt = (1 << CW) - 1;

    pc_redirect_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .iPC(pc), .iInstruction(ins), .iPredTaken(pt),
        .iStall(st), .iZeroE(z), .oNextPC(next_pc), .oFlush(flush), .oUpdValid(upd_v),
        .oUpdTaken(upd_t), .oUpdMiss(upd_m), .oBranchCnt(bcnt), .oMissCnt(mcnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] beq(input logic [15:0] imm);
        return {6'd4, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [AW-1:0] tgt(input logic [AW-1:0] p, input logic [15:0] imm);
        return p + 4 + {{(AW-18){imm[15]}}, imm, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        ins = NOP;
        pt  = 1'b0;
        st  = 1'b0;
        z   = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] p, input logic [15:0] imm, input logic prd);
        exp_t e;
        pc  = p;
        ins = beq(imm);
        pt  = prd;
        #1;
        chk("next_pc_if", next_pc, prd ? tgt(p, imm) : p + 4);
        e.pred = prd;
        e.alt  = prd ? p + 4 : tgt(p, imm);
        sb.push_back(e);
    endtask

    task automatic resolve(input logic zz);
        exp_t e;
        logic m;
        z = zz;
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_underflow: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            m = zz != e.pred;
            chk("upd_valid", upd_v, 1);
            chk("upd_taken", upd_t, zz);
            chk("upd_miss", upd_m, m);
            chk("flush", flush, m);
            if (m) chk("redirect_pc", next_pc, e.alt);
            ebc = ebc < max_cnt ? ebc + 1 : ebc;
            if (m) emc = emc < max_cnt ? emc + 1 : emc;
        end
        tick;
        chk("branch_cnt", bcnt, ebc);
        chk("miss_cnt", mcnt, emc);
    endtask

    initial begin
        idle;
        pc = 32'h40;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_next_pc", next_pc, 32'h44);
        chk("rst_flush", flush, 0);
        chk("rst_upd_valid", upd_v, 0);
        chk("rst_bcnt", bcnt, 0);
        chk("rst_mcnt", mcnt, 0);
        #10 rst_n = 1'b1;
        tick;

        // correct taken prediction
        issue(32'h100, 16'h0003, 1'b1);
        chk("tgt_0x110", next_pc, 32'h110);
        tick;
        idle; pc = 32'h110; #1;
        chk("no_upd_in_id", upd_v, 0);
        tick;
        resolve(1'b1);
        idle; #1;
        chk("after_correct_valid", upd_v, 0);
        tick;

        // taken mispredict
        issue(32'h100, 16'h0003, 1'b1);
        tick;
        idle; tick;
        resolve(1'b0);
        chk("flush_drops_after", upd_v, 0);
        tick;
        chk("trackers_empty", upd_v, 0);
        chk("no_flush_empty", flush, 0);

        // not-taken mispredict, negative offset
        issue(32'h200, 16'hFFFE, 1'b0);
        chk("seq_0x204", next_pc, 32'h204);
        tick;
        idle; tick;
        resolve(1'b1);
        tick;

        // flush kills younger beq B and an untracked IF beq C
        issue(32'h300, 16'h0004, 1'b0);
        tick;
        pc = 32'h304; ins = beq(16'h0001); pt = 1'b1;
        tick;
        pc = 32'h308; ins = beq(16'h0010); pt = 1'b1;
        resolve(1'b1);
        idle; z = 1'b1; #1;
        chk("killed_b_1", upd_v, 0);
        tick;
        chk("killed_b_2", upd_v, 0);
        tick;
        chk("killed_c", upd_v, 0);
        idle;
        tick;

        // stall while beq in D
        issue(32'h400, 16'h0002, 1'b1);
        tick;
        idle; st = 1'b1; #1;
        chk("stall_1", upd_v, 0);
        tick;
        #1 chk("stall_2", upd_v, 0);
        tick;
        st = 1'b0; #1;
        chk("stall_release", upd_v, 0);
        tick;
        resolve(1'b1);

        // correct prediction under stall pulses once
        issue(32'h500, 16'h0001, 1'b0);
        tick;
        idle; tick;
        st = 1'b1;
        resolve(1'b0);
        chk("stall_single_pulse", upd_v, 0);
        st = 1'b0;
        tick;

        // saturation
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            issue(32'h600, 16'h0001, 1'b1);
            tick;
            idle; tick;
            resolve(1'b0);
        end
        chk("sat_bcnt", bcnt, max_cnt);
        chk("sat_mcnt", mcnt, max_cnt);

        // async reset while beq in E
        issue(32'h700, 16'h0001, 1'b1);
        tick;
        idle; tick;
        z = 1'b1; #1;
        chk("pre_reset_valid", upd_v, 1);
        rst_n = 1'b0; #1;
        chk("reset_upd_valid", upd_v, 0);
        chk("reset_bcnt", bcnt, 0);
        chk("reset_mcnt", mcnt, 0);
        void'(sb.pop_front());
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer end of the branch-prediction interface.
- Takes the predictor's taken bit for the beq in IF and forms the fetch next-PC.
- Carries each prediction and its alternate PC through ID and EX.
- Resolves against the EX compare result, then issues redirect/flush to the pipeline and update feedback (valid/taken/mispredict) to the 2-bit predictor.
- Holds saturating branch and mispredict statistics counters.

Parameters:
- ADDR_W, 32, PC/address width.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- iPC  input  ADDR_W  PC of the instruction currently in IF.
- iInstruction  input  32  instruction in IF.
- iPredTaken  input  1  predictor's taken prediction for the IF instruction.
- iStall  input  1  hazard stall: hold PC and IF/ID, inject bubble into ID/EX.
- iZeroE  input  1  EX-stage compare-equal result.
- oNextPC  output  ADDR_W  next fetch PC.
- oFlush  output  1  kill IF/ID and ID/EX contents (mispredict).
- oUpdValid  output  1  a beq resolved in EX this cycle.
- oUpdTaken  output  1  actual outcome of the resolved beq.
- oUpdMiss  output  1  resolved beq was mispredicted.
- oBranchCnt  output  CNT_W  resolved beq count.
- oMissCnt  output  CNT_W  mispredict count.

Behaviour:
- IF decode:
  - beq_if = (iInstruction[31:26] == 6'd4).
  - seq = iPC + 4.
  - tgt = iPC + 4 + (sign-extended iInstruction[15:0] << 2), computed modulo 2^ADDR_W with wrap-around allowed.
  - predIF = beq_if & iPredTaken.
  - chosen = predIF ? tgt : seq.
  - altIF = predIF ? seq : tgt.
- Trackers: two slots, D (ID) and E (EX), each holding {valid, pred, alt_pc}.
- Resolution (combinational):
  - Valid only when E.valid.
  - actual = iZeroE; miss = (actual != E.pred).
  - oUpdValid = E.valid; oUpdTaken = E.valid & iZeroE; oUpdMiss = E.valid & miss.
  - All are 0 when E.valid = 0; iZeroE is ignored then.
- Next-PC priority:
  - E.valid & miss: oNextPC = E.alt_pc, oFlush = 1.
  - Otherwise oNextPC = chosen, oFlush = 0.
  - oNextPC is meaningful only when iStall = 0, or when oFlush = 1. The PC register loads on (!iStall | oFlush).
- Tracker update at posedge clk:
  - oFlush = 1: D.valid <= 0, E.valid <= 0 (the wrong-path instructions in ID and IF are dropped). The flush overrides iStall.
  - else if iStall = 1: D holds; E.valid <= 0 (bubble).
  - else: E <= D; D <= {beq_if, predIF, altIF}.
- Latency:
  - Prediction to resolution is 2 cycles without stalls.
  - Mispredict redirect takes effect on the next clock edge.
  - Mispredict penalty is 2 instructions.
- Counters:
  - oBranchCnt increments on oUpdValid.
  - oMissCnt increments on oUpdMiss.
  - Both saturate at all-ones and never wrap.
- Reset (async):
  - D.valid = E.valid = 0, pred = 0, alt_pc = 0, counters = 0.
  - Hence oFlush = 0, oUpd* = 0, oNextPC = iPC + 4 for non-beq.
  - Reset mid-operation drops in-flight branches with no update pulse.
- Simultaneous events:
  - EX mispredict plus a predicted-taken beq in IF: the redirect wins and the IF beq is not tracked.
  - Back-to-back beqs each resolve independently.
  - A beq sitting in D when an older beq mispredicts is discarded and never updates the predictor.
  - Correct prediction with iStall = 1: the update still pulses once, because E empties to a bubble.

Decomposition:
- Shared package holds:
  - OPC_BEQ = 6'd4.
  - Tracker record type {valid, pred, alt_pc[ADDR_W]}.
  - The PC increment constant, 4.
- One sub-module, pred_track_slot: a tracker register with load, hold and clear controls. It is instantiated for D and E.

Test Plan:
- Correct taken prediction:
  - Stimulus: iPC = 0x100, beq with imm = 0x0003, iPredTaken = 1.
  - Required: oNextPC = 0x110. Two cycles later, with iZeroE = 1: oUpdValid = 1, oUpdTaken = 1, oUpdMiss = 0, oFlush = 0, oBranchCnt = 1.
- Taken mispredict:
  - Stimulus: same beq at iPC = 0x100, iPredTaken = 1, iZeroE = 0 at resolution.
  - Required: oFlush = 1, oNextPC = 0x104, oUpdMiss = 1, oMissCnt = 1. Next cycle both trackers are empty and oUpdValid = 0.
- Not-taken mispredict with negative offset:
  - Stimulus: iPC = 0x200, imm = 0xFFFE, iPredTaken = 0, iZeroE = 1 at resolution.
  - Required: IF oNextPC = 0x204. At resolution: oFlush = 1, oNextPC = 0x1FC.
- Flush kills a younger branch:
  - Stimulus: beq A (mispredict) followed immediately by beq B.
  - Required: one oUpdValid pulse only, for A. B never resolves. oBranchCnt = 1.
- Stall:
  - Stimulus: beq in D with iStall = 1 for 2 cycles.
  - Required: D holds, no oUpdValid during the stall. The branch resolves 1 cycle after the stall drops.
- Saturation and reset:
  - Stimulus (1): force 2^CNT_W + 3 resolved mispredicts.
  - Required (1): both counters stay at 0xFFFF.
  - Stimulus (2): assert rst_n low while a beq is in E.
  - Required (2): counters = 0 and oUpdValid = 0 immediately.
